// File: rtl/acs_trellis_unit_if.sv
// rtl/acs_trellis_unit_if.sv - branch-metric input and ACS result bundle for the trellis unit
interface acs_trellis_unit_if #(
  parameter int K    = 4,
  parameter int BM_W = 2,
  parameter int PM_W = 8
);
  localparam int M  = K - 1;
  localparam int NS = 1 << M;

  logic                 start_i;
  logic                 in_valid_i;
  logic [4*BM_W-1:0]    bm_i;
  logic                 out_valid_o;
  logic [NS-1:0]        dec_o;
  logic [M-1:0]         best_state_o;
  logic [PM_W-1:0]      best_metric_o;
  logic                 norm_o;
  logic [NS*PM_W-1:0]   pm_o;
  logic [NS-1:0]        pm_valid_o;

  modport master (
    output start_i, in_valid_i, bm_i,
    input  out_valid_o, dec_o, best_state_o, best_metric_o, norm_o, pm_o, pm_valid_o
  );

  modport slave (
    input  start_i, in_valid_i, bm_i,
    output out_valid_o, dec_o, best_state_o, best_metric_o, norm_o, pm_o, pm_valid_o
  );
endinterface

// File: rtl/acs_trellis_unit.sv
// rtl/acs_trellis_unit.sv - add-compare-select array with normalisation and best-state search
module acs_trellis_unit #(
  parameter int             K    = 4,
  parameter logic [K-1:0]   G0   = 4'b1111,
  parameter logic [K-1:0]   G1   = 4'b1101,
  parameter int             BM_W = 2,
  parameter int             PM_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  acs_trellis_unit_if.slave  bus
);
  localparam int M  = K - 1;
  localparam int NS = 1 << M;
  localparam logic [NS-1:0]   START_VALID = NS'(1);
  localparam logic [PM_W-1:0] PM_HALF     = {1'b1, {(PM_W-1){1'b0}}};

  logic [NS*PM_W-1:0] pm_q, pm_d;
  logic [NS-1:0]      pm_valid_q, pm_valid_d;
  logic [NS-1:0]      dec_q, dec_d;
  logic [M-1:0]       best_state_q, best_state_d;
  logic [PM_W-1:0]    best_metric_q, best_metric_d;
  logic               out_valid_q, out_valid_d;
  logic               norm_q, norm_d;

  logic [NS*PM_W-1:0] acs_pm, post_pm;
  logic [NS-1:0]      acs_valid, acs_dec;
  logic               norm_hit;
  logic [M-1:0]       best_state_c;
  logic [PM_W-1:0]    best_metric_c;

  // Expected coded symbol {c0,c1} for encoder register contents r.
  function automatic logic [1:0] sym_of(input logic [K-1:0] r);
    return {^(r & G0), ^(r & G1)};
  endfunction

  // Path metric plus branch metric, clamped at the all-ones metric.
  function automatic logic [PM_W-1:0] sat_add(input logic [PM_W-1:0] a, input logic [BM_W-1:0] b);
    logic [PM_W:0] sum;
    sum = {1'b0, a} + (PM_W+1)'(b);
    return sum[PM_W] ? {PM_W{1'b1}} : sum[PM_W-1:0];
  endfunction

  // ACS for every next state; a frame start replaces the stored metrics with the initial set.
  always_comb begin
    logic [NS*PM_W-1:0] prev_pm;
    logic [NS-1:0]      prev_valid;
    logic [M-1:0]       ns_v, s0, s1;
    logic [1:0]         sym0, sym1;
    logic [PM_W-1:0]    cost0, cost1;
    logic               v0, v1, pick1;
    prev_pm    = bus.start_i ? '0 : pm_q;
    prev_valid = bus.start_i ? START_VALID : pm_valid_q;
    acs_pm     = '0;
    acs_valid  = '0;
    acs_dec    = '0;
    ns_v = '0; s0 = '0; s1 = '0; sym0 = '0; sym1 = '0;
    cost0 = '0; cost1 = '0; v0 = 1'b0; v1 = 1'b0; pick1 = 1'b0;
    for (int ns = 0; ns < NS; ns++) begin
      ns_v  = M'(ns);
      s0    = {ns_v[M-2:0], 1'b0};
      s1    = {ns_v[M-2:0], 1'b1};
      sym0  = sym_of({ns_v[M-1], s0});
      sym1  = sym_of({ns_v[M-1], s1});
      cost0 = sat_add(prev_pm[int'(s0)*PM_W +: PM_W], bus.bm_i[int'(sym0)*BM_W +: BM_W]);
      cost1 = sat_add(prev_pm[int'(s1)*PM_W +: PM_W], bus.bm_i[int'(sym1)*BM_W +: BM_W]);
      v0    = prev_valid[s0];
      v1    = prev_valid[s1];
      // Ties keep path 0; a lone valid predecessor always wins.
      pick1 = v1 && (!v0 || (cost0 > cost1));
      acs_dec[ns]   = pick1;
      acs_valid[ns] = v0 | v1;
      acs_pm[ns*PM_W +: PM_W] = (v0 | v1) ? (pick1 ? cost1 : cost0) : '0;
    end
  end

  // Modulo normalisation when every live metric sits in the upper half, then best-state search.
  always_comb begin
    logic found;
    norm_hit = |acs_valid;
    for (int ns = 0; ns < NS; ns++) begin
      if (acs_valid[ns] && !acs_pm[ns*PM_W + PM_W - 1]) norm_hit = 1'b0;
    end
    post_pm = acs_pm;
    for (int ns = 0; ns < NS; ns++) begin
      if (norm_hit && acs_valid[ns]) post_pm[ns*PM_W +: PM_W] = acs_pm[ns*PM_W +: PM_W] - PM_HALF;
    end
    found         = 1'b0;
    best_state_c  = '0;
    best_metric_c = '0;
    for (int ns = 0; ns < NS; ns++) begin
      if (acs_valid[ns] && (!found || (post_pm[ns*PM_W +: PM_W] < best_metric_c))) begin
        found         = 1'b1;
        best_state_c  = M'(ns);
        best_metric_c = post_pm[ns*PM_W +: PM_W];
      end
    end
  end

  // Commit a new trellis step only on a valid symbol; otherwise hold and drop the pulses.
  always_comb begin
    pm_d          = pm_q;
    pm_valid_d    = pm_valid_q;
    dec_d         = dec_q;
    best_state_d  = best_state_q;
    best_metric_d = best_metric_q;
    out_valid_d   = 1'b0;
    norm_d        = 1'b0;
    if (bus.in_valid_i) begin
      pm_d          = post_pm;
      pm_valid_d    = acs_valid;
      dec_d         = acs_dec;
      best_state_d  = best_state_c;
      best_metric_d = best_metric_c;
      out_valid_d   = 1'b1;
      norm_d        = norm_hit;
    end
  end

  // State registers; reset leaves the trellis in the frame-start condition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pm_q          <= '0;
      pm_valid_q    <= START_VALID;
      dec_q         <= '0;
      best_state_q  <= '0;
      best_metric_q <= '0;
      out_valid_q   <= 1'b0;
      norm_q        <= 1'b0;
    end else begin
      pm_q          <= pm_d;
      pm_valid_q    <= pm_valid_d;
      dec_q         <= dec_d;
      best_state_q  <= best_state_d;
      best_metric_q <= best_metric_d;
      out_valid_q   <= out_valid_d;
      norm_q        <= norm_d;
    end
  end

  assign bus.pm_o          = pm_q;
  assign bus.pm_valid_o    = pm_valid_q;
  assign bus.dec_o         = dec_q;
  assign bus.best_state_o  = best_state_q;
  assign bus.best_metric_o = best_metric_q;
  assign bus.out_valid_o   = out_valid_q;
  assign bus.norm_o        = norm_q;
endmodule

// File: tb/tb_acs_trellis_unit.sv
// tb/tb_acs_trellis_unit.sv - randomized scoreboard bench for acs_trellis_unit (K=4/PM_W=8 and K=3/PM_W=6)
module tb_acs_trellis_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  acs_trellis_unit_if #(.K(4), .BM_W(2), .PM_W(8)) if4 ();
  acs_trellis_unit_if #(.K(3), .BM_W(2), .PM_W(6)) if3 ();

  acs_trellis_unit #(.K(4), .G0(4'b1111), .G1(4'b1101), .BM_W(2), .PM_W(8))
    u_dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));
  acs_trellis_unit #(.K(3), .G0(3'b111), .G1(3'b101), .BM_W(2), .PM_W(6))
    u_dut3 (.clk(clk), .rst_n(rst_n), .bus(if3));

  // Reference model state: index 0 = K4 unit, index 1 = K3 unit.
  int mpm [2][8];
  bit mv  [2][8];
  int mdec[2];
  int mbs [2];
  int mbm [2];
  bit mnorm[2];
  bit mov [2];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset(input int d);
    for (int s = 0; s < 8; s++) begin
      mpm[d][s] = 0;
      mv[d][s]  = (s == 0);
    end
    mdec[d] = 0; mbs[d] = 0; mbm[d] = 0; mnorm[d] = 0; mov[d] = 0;
  endtask

  function automatic int parity(input int x);
    return $countones(x) & 1;
  endfunction

  // Forward trellis walk: every live old state pushes a candidate into both of its successors.
  task automatic model_step(input int d, input int k, input int g0, input int g1,
                            input int pmw, input bit start, input int bmword);
    int m, nst, maxv, half, nsx, r, sym, c, bmin;
    int old_pm[8];
    bit old_v[8];
    int cand[8][2];
    bit cv[8][2];
    bit pick, any, all_hi, found;
    m = k - 1; nst = 1 << m; maxv = (1 << pmw) - 1; half = 1 << (pmw - 1);
    for (int s = 0; s < 8; s++) begin
      old_pm[s] = start ? 0 : mpm[d][s];
      old_v[s]  = start ? (s == 0) : mv[d][s];
      cand[s][0] = 0; cand[s][1] = 0; cv[s][0] = 0; cv[s][1] = 0;
    end
    for (int s = 0; s < nst; s++) begin
      if (old_v[s]) begin
        for (int b = 0; b < 2; b++) begin
          nsx = (b << (m - 1)) | (s >> 1);
          r   = (b << m) | s;
          sym = 2 * parity(r & g0) + parity(r & g1);
          c   = old_pm[s] + ((bmword >> (2 * sym)) & 3);
          if (c > maxv) c = maxv;
          cand[nsx][s & 1] = c;
          cv[nsx][s & 1]   = 1;
        end
      end
    end
    mdec[d] = 0;
    for (int ns = 0; ns < 8; ns++) begin
      if (cv[ns][0] && cv[ns][1]) pick = cand[ns][0] > cand[ns][1];
      else pick = cv[ns][1];
      mv[d][ns]  = cv[ns][0] | cv[ns][1];
      mpm[d][ns] = mv[d][ns] ? cand[ns][pick] : 0;
      if (pick) mdec[d] |= (1 << ns);
    end
    any = 0; all_hi = 1;
    for (int ns = 0; ns < nst; ns++) begin
      if (mv[d][ns]) begin
        any = 1;
        if (mpm[d][ns] < half) all_hi = 0;
      end
    end
    mnorm[d] = any && all_hi;
    found = 0; mbs[d] = 0; bmin = 0;
    for (int ns = 0; ns < nst; ns++) begin
      if (mv[d][ns]) begin
        if (mnorm[d]) mpm[d][ns] -= half;
        if (!found || mpm[d][ns] < bmin) begin
          found = 1; mbs[d] = ns; bmin = mpm[d][ns];
        end
      end
    end
    mbm[d] = bmin;
    mov[d] = 1;
  endtask

  function automatic logic [63:0] pack_pm(input int d, input int nst, input int w);
    logic [63:0] v;
    v = '0;
    for (int s = 0; s < nst; s++) v |= 64'(mpm[d][s]) << (s * w);
    return v;
  endfunction

  function automatic logic [63:0] pack_v(input int d, input int nst);
    logic [63:0] v;
    v = '0;
    for (int s = 0; s < nst; s++) v[s] = mv[d][s];
    return v;
  endfunction

  // Model advances on the same edge the DUT samples its inputs.
  initial begin
    model_reset(0);
    model_reset(1);
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        model_reset(0);
        model_reset(1);
      end else begin
        if (if4.in_valid_i) model_step(0, 4, 'b1111, 'b1101, 8, if4.start_i, int'(if4.bm_i));
        else begin mov[0] = 0; mnorm[0] = 0; end
        if (if3.in_valid_i) model_step(1, 3, 'b111, 'b101, 6, if3.start_i, int'(if3.bm_i));
        else begin mov[1] = 0; mnorm[1] = 0; end
      end
    end
  end

  // Scoreboard: every output of both units against the model, mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && chk_en) begin
        chk("d4_out_valid", 64'(if4.out_valid_o),   64'(mov[0]));
        chk("d4_norm",      64'(if4.norm_o),        64'(mnorm[0]));
        chk("d4_dec",       64'(if4.dec_o),         64'(mdec[0]));
        chk("d4_pm_valid",  64'(if4.pm_valid_o),    pack_v(0, 8));
        chk("d4_pm",        64'(if4.pm_o),          pack_pm(0, 8, 8));
        chk("d4_best_st",   64'(if4.best_state_o),  64'(mbs[0]));
        chk("d4_best_met",  64'(if4.best_metric_o), 64'(mbm[0]));
        chk("d3_out_valid", 64'(if3.out_valid_o),   64'(mov[1]));
        chk("d3_norm",      64'(if3.norm_o),        64'(mnorm[1]));
        chk("d3_dec",       64'(if3.dec_o),         64'(mdec[1]));
        chk("d3_pm_valid",  64'(if3.pm_valid_o),    pack_v(1, 4));
        chk("d3_pm",        64'(if3.pm_o),          pack_pm(1, 4, 6));
        chk("d3_best_st",   64'(if3.best_state_o),  64'(mbs[1]));
        chk("d3_best_met",  64'(if3.best_metric_o), 64'(mbm[1]));
      end
    end
  end

  task automatic apply(input bit st4, input bit v4, input logic [7:0] b4,
                       input bit st3, input bit v3, input logic [7:0] b3);
    @(negedge clk);
    if4.start_i = st4; if4.in_valid_i = v4; if4.bm_i = b4;
    if3.start_i = st3; if3.in_valid_i = v3; if3.bm_i = b3;
    @(posedge clk);
    #1;
  endtask

  initial begin
    if4.start_i = 0; if4.in_valid_i = 0; if4.bm_i = '0;
    if3.start_i = 0; if3.in_valid_i = 0; if3.bm_i = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk_en = 1'b1;
    #1;
    chk("rst_out_valid", 64'(if4.out_valid_o), 64'h0);
    chk("rst_pm_valid",  64'(if4.pm_valid_o),  64'h01);
    chk("rst_pm",        64'(if4.pm_o),        64'h0);
    chk("rst3_pm_valid", 64'(if3.pm_valid_o),  64'h1);

    // First symbol from start with zero branch metrics.
    apply(1, 1, 8'h00, 0, 0, 8'h00);
    chk("first_out_valid", 64'(if4.out_valid_o),   64'h1);
    chk("first_pm_valid",  64'(if4.pm_valid_o),    64'h11);
    chk("first_dec",       64'(if4.dec_o),         64'h0);
    chk("first_best_st",   64'(if4.best_state_o),  64'h0);
    chk("first_best_met",  64'(if4.best_metric_o), 64'h0);

    // Fill the trellis, then penalise symbol 00 only: ns 0 and 6 must take path 1, rest tie to 0.
    apply(0, 1, 8'h00, 0, 0, 8'h00);
    apply(0, 1, 8'h00, 0, 0, 8'h00);
    chk("fill_pm_valid", 64'(if4.pm_valid_o), 64'hff);
    apply(0, 1, 8'h03, 0, 0, 8'h00);
    chk("tie_dec",      64'(if4.dec_o),         64'h41);
    chk("tie_best_met", 64'(if4.best_metric_o), 64'h0);

    // Async reset landing mid-cycle after some random activity.
    for (int i = 0; i < 6; i++) apply(0, 1, 8'($urandom), 0, 0, 8'h00);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("mrst_out_valid", 64'(if4.out_valid_o),  64'h0);
    chk("mrst_pm_valid",  64'(if4.pm_valid_o),   64'h01);
    chk("mrst_pm",        64'(if4.pm_o),         64'h0);
    chk("mrst_best_st",   64'(if4.best_state_o), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Normalisation: all-3 metrics from start; symbol 43 reaches 129 and folds to 1.
    apply(1, 1, 8'hff, 0, 0, 8'h00);
    chk("norm_early_1", 64'(if4.norm_o), 64'h0);
    for (int i = 2; i <= 42; i++) begin
      apply(0, 1, 8'hff, 0, 0, 8'h00);
      chk($sformatf("norm_early_%0d", i), 64'(if4.norm_o), 64'h0);
    end
    chk("norm_pre_best_met", 64'(if4.best_metric_o), 64'd126);
    apply(0, 1, 8'hff, 0, 0, 8'h00);
    chk("norm_pulse",    64'(if4.norm_o),        64'h1);
    chk("norm_best_met", 64'(if4.best_metric_o), 64'h1);
    chk("norm_pm",       64'(if4.pm_o),          64'h0101010101010101);

    // Gap with a stray start: everything holds.
    for (int i = 0; i < 5; i++) begin
      apply(1, 0, 8'h00, 1, 0, 8'h00);
      chk("gap_out_valid", 64'(if4.out_valid_o),   64'h0);
      chk("gap_pm",        64'(if4.pm_o),          64'h0101010101010101);
      chk("gap_best_met",  64'(if4.best_metric_o), 64'h1);
      chk("gap_pm_valid",  64'(if4.pm_valid_o),    64'hff);
    end
    apply(1, 1, 8'h00, 0, 0, 8'h00);
    chk("restart_out_valid", 64'(if4.out_valid_o),   64'h1);
    chk("restart_pm_valid",  64'(if4.pm_valid_o),    64'h11);
    chk("restart_dec",       64'(if4.dec_o),         64'h0);
    chk("restart_best_met",  64'(if4.best_metric_o), 64'h0);
    chk("restart_norm",      64'(if4.norm_o),        64'h0);

    // K=3, PM_W=6 unit: metric 3 on symbol 00 only, long run toward the top of the range.
    apply(0, 0, 8'h00, 1, 1, 8'h03);
    chk("k3_first_pm_valid", 64'(if3.pm_valid_o),    64'h5);
    chk("k3_first_pm",       64'(if3.pm_o),          64'h000003);
    chk("k3_first_best_st",  64'(if3.best_state_o),  64'h2);
    chk("k3_first_best_met", 64'(if3.best_metric_o), 64'h0);
    for (int i = 0; i < 300; i++) apply(0, 0, 8'h00, 0, 1, 8'h03);

    // Random symbols, gaps and restarts on both units.
    for (int i = 0; i < 10000; i++) begin
      apply($urandom_range(0, 63) == 0, $urandom_range(0, 7) != 0, 8'($urandom),
            $urandom_range(0, 63) == 0, $urandom_range(0, 7) != 0, 8'($urandom));
    end
    @(negedge clk);
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
